// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multicycle memory port between instruction fetch (I)
// and load/store (D); registers the winning request and routes the response back.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    // Handshake: a requester raises read/write and holds it with stable address/data until
    // its x_resp pulse; the arbiter samples it only in IDLE and ignores mem_resp outside SERVE.
    state_e          state_q, state_d;
    logic            last_d_q, last_d_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    // On a tie, I wins only when D was granted last.
    assign grant_i = i_req & (~d_req | last_d_q);
    assign grant_d = d_req & ~grant_i;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    read_d   = 1'b1;
                    write_d  = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = i_address;
                    wdata_d  = 32'h0;
                    cnt_d    = '0;
                end else if (grant_d) begin
                    // Read+write together is illegal and resolves to a write.
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    read_d   = ~d_write;
                    write_d  = d_write;
                    be_d     = d_write ? d_byte_enable : 4'hF;
                    addr_d   = d_address;
                    wdata_d  = d_wdata;
                    cnt_d    = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (cnt_q < CW'(TIMEOUT_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (cnt_d >= CW'(TIMEOUT_CYCLES)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign i_resp          = (state_q == SERVE_I) & mem_resp;
    assign d_resp          = (state_q == SERVE_D) & mem_resp;
    assign i_rdata         = i_resp ? mem_rdata : 32'h0;
    assign d_rdata         = d_resp ? mem_rdata : 32'h0;
    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign timeout         = timeout_q;
    assign dbg_state       = state_q;

endmodule
